// File: rtl/axis_sample_packer_if.sv
// axis_sample_packer_if: AXI4-Stream word channel between the packer and the DMA.
interface axis_sample_packer_if #(parameter int W = 32);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_sample_packer.sv
// axis_sample_packer: packs sample pairs into words, buffers them in a FIFO, emits AXIS packets.
module axis_sample_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [15:0]           pkt_len,
    input  logic                  in_data_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    axis_sample_packer_if.master  m_axis,
    output logic                  overflow,
    input  logic                  clear_overflow,
    output logic [FIFO_AW:0]      fifo_level
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int WW    = 2 * DATA_WIDTH;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state;
    logic                  phase, pend_vld;
    logic [DATA_WIDTH-1:0] lo;
    logic [WW-1:0]         pend_data;
    logic [15:0]           cnt, len_r, len_eff, cur_len;
    logic [WW:0]           mem [DEPTH];
    logic [FIFO_AW:0]      wp, rp, wp_nx, rp_nx;
    logic                  full, acc, wr_ok, wr_last, rd, pkt_start;
    always_comb begin
        len_eff   = pkt_len == 16'd0 ? 16'd1 : pkt_len;
        pkt_start = state == RUN && cnt == 16'd0;
        // a length change landing on a packet's first write must govern that write's tlast
        cur_len   = pkt_start ? len_eff : len_r;
        full      = wp[FIFO_AW] != rp[FIFO_AW] && wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0];
        acc       = state != IDLE && in_data_valid;
        wr_ok     = pend_vld && !full;
        wr_last   = cnt == cur_len - 16'd1;
        rd        = m_axis.tvalid && m_axis.tready;
        wp_nx     = wp + {{FIFO_AW{1'b0}}, wr_ok};
        rp_nx     = rp + {{FIFO_AW{1'b0}}, rd};
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            phase         <= 1'b0;
            pend_vld      <= 1'b0;
            lo            <= '0;
            pend_data     <= '0;
            cnt           <= '0;
            len_r         <= 16'd1;
            wp            <= '0;
            rp            <= '0;
            fifo_level    <= '0;
            overflow      <= 1'b0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tdata  <= '0;
        end else begin
            state <= state == IDLE ? (enable ? RUN : IDLE) :
                     state == RUN  ? (enable ? RUN : FLUSH) :
                     enable ? RUN :
                     (wr_ok && wr_last) || (cnt == 16'd0 && !phase && !pend_vld) ? IDLE : FLUSH;
            phase    <= state == IDLE ? 1'b0 : acc ? !phase : phase;
            pend_vld <= acc && phase;
            if (acc && !phase) lo <= in_data;
            if (acc && phase) pend_data <= {in_data, lo};
            if ((state == IDLE && enable) || pkt_start) len_r <= len_eff;
            if (wr_ok) begin
                mem[wp[FIFO_AW-1:0]] <= {wr_last, pend_data};
                cnt <= wr_last ? 16'd0 : cnt + 16'd1;
            end
            wp         <= wp_nx;
            rp         <= rp_nx;
            fifo_level <= wp_nx - rp_nx;
            overflow   <= (pend_vld && full) || (overflow && !clear_overflow);
            // output stage only sees words committed on earlier edges, so a slot is never read as it is written
            m_axis.tvalid                <= (wp - rp_nx) != '0;
            {m_axis.tlast, m_axis.tdata} <= mem[rp_nx[FIFO_AW-1:0]];
        end
    end
endmodule

// File: tb/tb_axis_sample_packer.sv
// tb_axis_sample_packer: directed scoreboard bench for the sample packer.
module tb_axis_sample_packer;
    logic        clk = 0, rst = 0, enable = 0, in_data_valid = 0, clear_overflow = 0;
    logic [15:0] pkt_len = 16'd4, in_data = '0;
    logic        overflow;
    logic [4:0]  fifo_level;
    logic [32:0] q[$];
    int          checks = 0, errors = 0;
    axis_sample_packer_if #(.W(32)) ax();
    axis_sample_packer #(.DATA_WIDTH(16), .FIFO_AW(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pkt_len(pkt_len),
        .in_data_valid(in_data_valid), .in_data(in_data), .m_axis(ax),
        .overflow(overflow), .clear_overflow(clear_overflow), .fifo_level(fifo_level)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic smp(input logic [15:0] d);
        in_data = d;
        in_data_valid = 1;
        step();
        in_data_valid = 0;
    endtask
    task automatic word(input logic [15:0] lo, input logic [15:0] hi, input logic last, input bit keep);
        smp(lo);
        smp(hi);
        if (keep) q.push_back({last, hi, lo});
    endtask
    task automatic drain(input string tag);
        for (int i = 0; i < 200 && q.size() != 0; i++) step();
        chk(tag, q.size(), 0);
    endtask
    always @(negedge clk) begin
        if (rst && ax.tvalid && ax.tready) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word: observed %0h expected none", {ax.tlast, ax.tdata});
            end
            if (q.size() != 0) chk("word", {ax.tlast, ax.tdata}, q.pop_front());
        end
    end
    initial begin
        ax.tready = 1;
        repeat (3) step();
        chk("rst_tvalid", ax.tvalid, 0);
        chk("rst_tlast", ax.tlast, 0);
        chk("rst_tdata", ax.tdata, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_level", fifo_level, 0);
        rst = 1;
        step();
        enable = 1;
        step();
        smp(16'h0001);
        smp(16'h0002);
        q.push_back({1'b0, 16'h0002, 16'h0001});
        chk("lat_k_tvalid", ax.tvalid, 0);
        step();
        chk("lat_k1_level", fifo_level, 1);
        chk("lat_k1_tvalid", ax.tvalid, 0);
        step();
        chk("lat_k2_tvalid", ax.tvalid, 1);
        for (int j = 1; j < 8; j++) word(16'(2 * j + 1), 16'(2 * j + 2), j % 4 == 3, 1);
        drain("basic_drain");
        chk("basic_overflow", overflow, 0);
        ax.tready = 0;
        for (int j = 0; j < 16; j++) word(16'(16'h1000 + 2 * j), 16'(16'h1001 + 2 * j), j % 4 == 3, 1);
        repeat (3) step();
        chk("bp_level16", fifo_level, 16);
        chk("bp_no_overflow", overflow, 0);
        chk("bp_head", {ax.tvalid, ax.tlast, ax.tdata}, {2'b10, 16'h1001, 16'h1000});
        word(16'hdead, 16'hbeef, 0, 0);
        step();
        chk("drop_level", fifo_level, 16);
        chk("drop_overflow", overflow, 1);
        word(16'h5555, 16'h6666, 0, 0);
        clear_overflow = 1;
        step();
        clear_overflow = 0;
        chk("ovf_race_set_wins", overflow, 1);
        clear_overflow = 1;
        step();
        clear_overflow = 0;
        chk("ovf_cleared", overflow, 0);
        ax.tready = 1;
        drain("bp_drain");
        repeat (2) step();
        chk("bp_level0", fifo_level, 0);
        pkt_len = 0;
        for (int j = 0; j < 3; j++) word(16'(16'h2000 + j), 16'(16'h2100 + j), 1, 1);
        drain("len0_drain");
        pkt_len = 4;
        step();
        word(16'h3000, 16'h3001, 0, 1);
        step();
        pkt_len = 2;
        word(16'h3002, 16'h3003, 0, 1);
        word(16'h3004, 16'h3005, 0, 1);
        word(16'h3006, 16'h3007, 1, 1);
        word(16'h3008, 16'h3009, 0, 1);
        word(16'h300a, 16'h300b, 1, 1);
        drain("lenchg_drain");
        pkt_len = 4;
        step();
        word(16'h4000, 16'h4001, 0, 1);
        word(16'h4002, 16'h4003, 0, 1);
        step();
        enable = 0;
        word(16'h4004, 16'h4005, 0, 1);
        word(16'h4006, 16'h4007, 1, 1);
        drain("stop_drain");
        repeat (3) step();
        word(16'h4444, 16'h4445, 0, 0);
        word(16'h4446, 16'h4447, 0, 0);
        repeat (6) step();
        chk("stop_level", fifo_level, 0);
        chk("stop_tvalid", ax.tvalid, 0);
        enable = 1;
        step();
        ax.tready = 0;
        for (int j = 0; j < 5; j++) word(16'(16'h5000 + 2 * j), 16'(16'h5001 + 2 * j), 0, 0);
        smp(16'h50ff);
        repeat (3) step();
        chk("pre_rst_level", fifo_level, 5);
        chk("pre_rst_tvalid", ax.tvalid, 1);
        rst = 0;
        step();
        chk("mid_rst_tvalid", ax.tvalid, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_overflow", overflow, 0);
        ax.tready = 1;
        rst = 1;
        step();
        for (int j = 0; j < 4; j++) word(16'(16'h6000 + 2 * j), 16'(16'h6001 + 2 * j), j == 3, 1);
        drain("post_rst_drain");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
